driver_motores_paso: RTL and testbench

//  Consumer of the 2-bit tracker motor commands (00 stop, 01 horario, 11 anti-horario).

---
 rtl/movimiento_pkg.sv | 53 +++++
 rtl/driver_motores_paso_if.sv | 24 ++
 rtl/eje_paso.sv | 157 +++++++++++++++
 rtl/driver_motores_paso.sv | 79 +++++++
 tb/tb_driver_motores_paso.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/movimiento_pkg.sv
// Shared definitions for the stepper driver: command codes, axis FSM states and coil phase tables.
// Build option HALF_STEP_EN selects the 8-entry half-step table; the default build uses the 4-entry full-step table.
package movimiento_pkg;

  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_CW   = 2'b01;
  localparam logic [1:0] CMD_CCW  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_RUN      = 2'b01,
    ST_REV_WAIT = 2'b10
  } eje_estado_e;

`ifdef HALF_STEP_EN
  localparam int PHASE_LEN = 8;
`else
  localparam int PHASE_LEN = 4;
`endif
  localparam logic [2:0] PHASE_MASK = 3'(PHASE_LEN - 1);

  // idx counts steps taken modulo the table length; the pattern reached after idx steps is
  // entry idx-1, so the very first cw step out of reset drives table entry 0.
  function automatic logic [3:0] fase_bobina(input logic [2:0] idx);
    logic [2:0] ent;
    logic [3:0] pat;
    ent = (idx - 3'd1) & PHASE_MASK;
    pat = 4'b0000;
`ifdef HALF_STEP_EN
    case (ent)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`else
    case (ent)
      3'd0:    pat = 4'b1100;
      3'd1:    pat = 4'b0110;
      3'd2:    pat = 4'b0011;
      3'd3:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
`endif
    return pat;
  endfunction

endpackage

// File: rtl/driver_motores_paso_if.sv
// Command/feedback bundle between the tracker movement controller (master) and the stepper driver (slave).
interface driver_motores_paso_if;

  logic [1:0]  s_out_theta;
  logic [1:0]  s_out_phi;
  logic        pos_clr;
  logic [3:0]  coil_theta;
  logic [3:0]  coil_phi;
  logic [15:0] theta_actual;
  logic [15:0] phi_actual;
  logic        busy_theta;
  logic        busy_phi;

  modport master (
    output s_out_theta, s_out_phi, pos_clr,
    input  coil_theta, coil_phi, theta_actual, phi_actual, busy_theta, busy_phi
  );

  modport slave (
    input  s_out_theta, s_out_phi, pos_clr,
    output coil_theta, coil_phi, theta_actual, phi_actual, busy_theta, busy_phi
  );

endinterface

// File: rtl/eje_paso.sv
// One stepper axis: IDLE/RUN/REV_WAIT FSM, phase index, wrap-around position, hold and reversal-gap counters.
// Everything advances only on the shared step tick; outputs are registered.
module eje_paso
  import movimiento_pkg::*;
#(
  parameter int STEPS_REV  = 2048,
  parameter int REV_GAP    = 4,
  parameter int HOLD_TICKS = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick_i,
  input  logic        pos_clr_i,
  input  logic [1:0]  cmd_i,
  output logic [3:0]  coil_o,
  output logic [15:0] pos_o,
  output logic        busy_o
);

  localparam logic [15:0] POS_MAX = 16'(STEPS_REV - 1);
  localparam int IDLE_W = $clog2(HOLD_TICKS + 1);
  localparam logic [IDLE_W-1:0] IDLE_LIM = IDLE_W'(HOLD_TICKS);
  // Reversal costs the entry tick plus GAP_TICKS waiting ticks before the new direction may step.
  localparam int GAP_TICKS = (REV_GAP > 1) ? (REV_GAP - 1) : 1;
  localparam int GAP_W = $clog2(GAP_TICKS + 1);
  localparam logic [GAP_W-1:0] GAP_LIM = GAP_W'(GAP_TICKS);

  eje_estado_e       state_q, state_d;
  logic              dir_q, dir_d;
  logic [2:0]        idx_q, idx_d;
  logic [15:0]       pos_q, pos_d;
  logic [3:0]        coil_q, coil_d;
  logic              busy_q, busy_d;
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic [GAP_W-1:0]  gap_next_s;
  logic              want_cw_s, want_ccw_s, moving_s;
  logic              step_s, release_s;

  assign want_cw_s  = (cmd_i == CMD_CW);
  assign want_ccw_s = (cmd_i == CMD_CCW);
  assign moving_s   = want_cw_s | want_ccw_s;

  always_comb begin
    state_d    = state_q;
    dir_d      = dir_q;
    idle_cnt_d = idle_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    step_s     = 1'b0;
    release_s  = 1'b0;
    gap_next_s = gap_cnt_q + 1'b1;
    if (tick_i) begin
      case (state_q)
        ST_IDLE: begin
          if (moving_s) begin
            state_d    = ST_RUN;
            dir_d      = want_ccw_s;
            step_s     = 1'b1;
            idle_cnt_d = '0;
          end else if (idle_cnt_q != IDLE_LIM) begin
            idle_cnt_d = idle_cnt_q + 1'b1;
            release_s  = (idle_cnt_d == IDLE_LIM);
          end else begin
            idle_cnt_d = idle_cnt_q;
          end
        end
        ST_RUN: begin
          if (!moving_s) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
          end else if (want_ccw_s == dir_q) begin
            step_s = 1'b1;
          end else begin
            state_d   = ST_REV_WAIT;
            gap_cnt_d = '0;
          end
        end
        ST_REV_WAIT: begin
          if (!moving_s) begin
            state_d    = ST_IDLE;
            idle_cnt_d = '0;
          end else if (gap_next_s >= GAP_LIM) begin
            state_d   = ST_RUN;
            dir_d     = want_ccw_s;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_next_s;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          idle_cnt_d = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d != ST_IDLE);
  end

  // A coinciding pos_clr wins over the step: position zeroes, phase and coils stay put.
  always_comb begin
    idx_d  = idx_q;
    coil_d = coil_q;
    pos_d  = pos_q;
    if (step_s && !pos_clr_i) begin
      if (dir_d) begin
        idx_d = (idx_q - 3'd1) & PHASE_MASK;
      end else begin
        idx_d = (idx_q + 3'd1) & PHASE_MASK;
      end
      coil_d = fase_bobina(idx_d);
    end else if (release_s) begin
      coil_d = 4'b0000;
    end else begin
      coil_d = coil_q;
    end
    if (pos_clr_i) begin
      pos_d = 16'd0;
    end else if (step_s) begin
      if (dir_d) begin
        pos_d = (pos_q == 16'd0) ? POS_MAX : (pos_q - 16'd1);
      end else begin
        pos_d = (pos_q == POS_MAX) ? 16'd0 : (pos_q + 16'd1);
      end
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      dir_q      <= 1'b0;
      idx_q      <= 3'd0;
      pos_q      <= 16'd0;
      coil_q     <= 4'b0000;
      busy_q     <= 1'b0;
      idle_cnt_q <= '0;
      gap_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      idx_q      <= idx_d;
      pos_q      <= pos_d;
      coil_q     <= coil_d;
      busy_q     <= busy_d;
      idle_cnt_q <= idle_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
    end
  end

  assign coil_o = coil_q;
  assign pos_o  = pos_q;
  assign busy_o = busy_q;

endmodule

// File: rtl/driver_motores_paso.sv
// Stepper driver top: shared step-tick generator feeding the theta and phi axes, with pos_clr fanned out to both.
// Phase table selected by HALF_STEP_EN (full-step when undefined).
module driver_motores_paso
  import movimiento_pkg::*;
#(
  parameter int STEP_DIV   = 50000,
  parameter int STEPS_REV  = 2048,
  parameter int REV_GAP    = 4,
  parameter int HOLD_TICKS = 100
) (
  input logic                  clk,
  input logic                  rst_n,
  driver_motores_paso_if.slave bus
);

  localparam int CNT_W = $clog2(STEP_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STEP_DIV - 1);

  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick_s;
  logic [3:0]       coil_theta_s, coil_phi_s;
  logic [15:0]      theta_pos_s, phi_pos_s;
  logic             busy_theta_s, busy_phi_s;

  always_comb begin
    tick_s = (tick_cnt_q == CNT_MAX);
    if (tick_s) begin
      tick_cnt_d = '0;
    end else begin
      tick_cnt_d = tick_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  eje_paso #(
    .STEPS_REV (STEPS_REV),
    .REV_GAP   (REV_GAP),
    .HOLD_TICKS(HOLD_TICKS)
  ) u_eje_theta (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick_s),
    .pos_clr_i(bus.pos_clr),
    .cmd_i    (bus.s_out_theta),
    .coil_o   (coil_theta_s),
    .pos_o    (theta_pos_s),
    .busy_o   (busy_theta_s)
  );

  eje_paso #(
    .STEPS_REV (STEPS_REV),
    .REV_GAP   (REV_GAP),
    .HOLD_TICKS(HOLD_TICKS)
  ) u_eje_phi (
    .clk      (clk),
    .rst_n    (rst_n),
    .tick_i   (tick_s),
    .pos_clr_i(bus.pos_clr),
    .cmd_i    (bus.s_out_phi),
    .coil_o   (coil_phi_s),
    .pos_o    (phi_pos_s),
    .busy_o   (busy_phi_s)
  );

  assign bus.coil_theta   = coil_theta_s;
  assign bus.coil_phi     = coil_phi_s;
  assign bus.theta_actual = theta_pos_s;
  assign bus.phi_actual   = phi_pos_s;
  assign bus.busy_theta   = busy_theta_s;
  assign bus.busy_phi     = busy_phi_s;

endmodule

// File: tb/tb_driver_motores_paso.sv
// Randomised scoreboard bench for driver_motores_paso (full-step build, small parameters).
module tb_driver_motores_paso;

  localparam int STEP_DIV   = 4;
  localparam int STEPS_REV  = 8;
  localparam int REV_GAP    = 2;
  localparam int HOLD_TICKS = 3;
  localparam int TBL        = 4;

  localparam int M_IDLE = 0;
  localparam int M_MOVE = 1;
  localparam int M_TURN = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  driver_motores_paso_if bus();

  driver_motores_paso #(
    .STEP_DIV  (STEP_DIV),
    .STEPS_REV (STEPS_REV),
    .REV_GAP   (REV_GAP),
    .HOLD_TICKS(HOLD_TICKS)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [3:0]  coil_t;
    logic [3:0]  coil_p;
    logic [15:0] pos_t;
    logic [15:0] pos_p;
    logic        busy_t;
    logic        busy_p;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  // Reference model: plain integers per axis, driven once per clock edge.
  logic [3:0] tabla [TBL] = '{4'b1100, 4'b0110, 4'b0011, 4'b1001};
  int         m_cnt;
  int         m_mode  [2];
  int         m_dir   [2];
  int         m_steps [2];
  int         m_pos   [2];
  int         m_idle  [2];
  int         m_wait  [2];
  logic [3:0] m_coil  [2];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0;
    for (int a = 0; a < 2; a++) begin
      m_mode[a] = M_IDLE; m_dir[a] = 1; m_steps[a] = 0; m_pos[a] = 0;
      m_idle[a] = 0; m_wait[a] = 0; m_coil[a] = 4'b0000;
    end
  endtask

  task automatic model_axis(input int a, input bit tk, input logic clr, input logic [1:0] cmd);
    int  want;
    bit  go;
    want = (cmd == 2'b01) ? 1 : ((cmd == 2'b11) ? -1 : 0);
    go   = 1'b0;
    if (tk) begin
      if (m_mode[a] == M_IDLE) begin
        if (want != 0) begin
          m_mode[a] = M_MOVE; m_dir[a] = want; go = 1'b1; m_idle[a] = 0;
        end else if (m_idle[a] < HOLD_TICKS) begin
          m_idle[a]++;
          if (m_idle[a] == HOLD_TICKS) m_coil[a] = 4'b0000;
        end
      end else if (m_mode[a] == M_MOVE) begin
        if (want == 0) begin
          m_mode[a] = M_IDLE; m_idle[a] = 0;
        end else if (want == m_dir[a]) begin
          go = 1'b1;
        end else begin
          m_mode[a] = M_TURN; m_wait[a] = (REV_GAP > 1) ? REV_GAP - 1 : 1;
        end
      end else begin
        if (want == 0) begin
          m_mode[a] = M_IDLE; m_idle[a] = 0;
        end else begin
          m_wait[a]--;
          if (m_wait[a] == 0) begin
            m_mode[a] = M_MOVE; m_dir[a] = want;
          end
        end
      end
    end
    if (go && !clr) begin
      m_steps[a] = (m_steps[a] + m_dir[a] + TBL) % TBL;
      m_pos[a]   = (m_pos[a] + m_dir[a] + STEPS_REV) % STEPS_REV;
      m_coil[a]  = tabla[(m_steps[a] + TBL - 1) % TBL];
    end
    if (clr) m_pos[a] = 0;
  endtask

  task automatic model_edge(input logic [1:0] ct, input logic [1:0] cp, input logic clr);
    bit   tk;
    obs_t e;
    tk    = (m_cnt == STEP_DIV - 1);
    m_cnt = tk ? 0 : m_cnt + 1;
    model_axis(0, tk, clr, ct);
    model_axis(1, tk, clr, cp);
    e.coil_t = m_coil[0];
    e.coil_p = m_coil[1];
    e.pos_t  = 16'(m_pos[0]);
    e.pos_p  = 16'(m_pos[1]);
    e.busy_t = (m_mode[0] != M_IDLE);
    e.busy_p = (m_mode[1] != M_IDLE);
    exp_q.push_back(e);
  endtask

  task automatic apply(input logic [1:0] ct, input logic [1:0] cp, input logic clr);
    bus.s_out_theta = ct;
    bus.s_out_phi   = cp;
    bus.pos_clr     = clr;
    model_edge(ct, cp, clr);
  endtask

  task automatic drive(input logic [1:0] ct, input logic [1:0] cp, input logic clr);
    @(negedge clk);
    apply(ct, cp, clr);
  endtask

  task automatic run_ticks(input logic [1:0] ct, input logic [1:0] cp, input int n);
    for (int i = 0; i < n * STEP_DIV; i++) drive(ct, cp, 1'b0);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, " coil_theta"},   16'(bus.coil_theta), 16'd0);
    chk({nm, " coil_phi"},     16'(bus.coil_phi),   16'd0);
    chk({nm, " theta_actual"}, bus.theta_actual,    16'd0);
    chk({nm, " phi_actual"},   bus.phi_actual,      16'd0);
    chk({nm, " busy_theta"},   16'(bus.busy_theta), 16'd0);
    chk({nm, " busy_phi"},     16'(bus.busy_phi),   16'd0);
  endtask

  // Hold reset over a few edges, then release on a falling edge and issue the first post-reset cycle.
  task automatic reset_and_release();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    apply(2'b00, 2'b00, 1'b0);
  endtask

  function automatic logic [1:0] pick_cmd();
    return 2'($urandom_range(0, 3));
  endfunction

  // Monitor: one expected observation per post-reset clock edge.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("coil_theta",   16'(bus.coil_theta), 16'(mon_e.coil_t));
      chk("coil_phi",     16'(bus.coil_phi),   16'(mon_e.coil_p));
      chk("theta_actual", bus.theta_actual,    mon_e.pos_t);
      chk("phi_actual",   bus.phi_actual,      mon_e.pos_p);
      chk("busy_theta",   16'(bus.busy_theta), 16'(mon_e.busy_t));
      chk("busy_phi",     16'(bus.busy_phi),   16'(mon_e.busy_p));
    end
  end

  initial begin
    logic [1:0] rt, rp;
    rst_n = 1'b0;
    bus.s_out_theta = 2'b00;
    bus.s_out_phi   = 2'b00;
    bus.pos_clr     = 1'b0;
    model_reset();
    #3;
    chk_all_zero("reset");
    reset_and_release();

    run_ticks(2'b01, 2'b00, 4);
    @(posedge clk); #2;
    chk("4 cw ticks theta_actual", bus.theta_actual, 16'd4);
    chk("4 cw ticks coil_theta", 16'(bus.coil_theta), 16'(4'b1001));
    chk("4 cw ticks busy_theta", 16'(bus.busy_theta), 16'd1);

    run_ticks(2'b01, 2'b11, 6);
    run_ticks(2'b11, 2'b11, 5);
    run_ticks(2'b00, 2'b11, 5);
    run_ticks(2'b01, 2'b01, 3);

    while (m_cnt != STEP_DIV - 1) drive(2'b01, 2'b11, 1'b0);
    drive(2'b01, 2'b11, 1'b1);
    @(posedge clk); #2;
    chk("pos_clr theta_actual", bus.theta_actual, 16'd0);
    chk("pos_clr phi_actual", bus.phi_actual, 16'd0);

    rt = 2'b01;
    rp = 2'b11;
    for (int c = 0; c < 1600; c++) begin
      if ($urandom_range(0, 19) == 0) rt = pick_cmd();
      if ($urandom_range(0, 19) == 0) rp = pick_cmd();
      drive(rt, rp, ($urandom_range(0, 59) == 0));
    end

    run_ticks(2'b01, 2'b11, 3);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid-run reset");
    reset_and_release();

    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 15) == 0) rt = pick_cmd();
      if ($urandom_range(0, 15) == 0) rp = pick_cmd();
      drive(rt, rp, ($urandom_range(0, 79) == 0));
    end

    @(posedge clk); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
